// File: rtl/barret_feeder_pkg.sv
// barret_feeder_pkg: constants shared by the feeder, the Barrett reducer and NTT control
package barret_feeder_pkg;
   localparam int OP_W  = 32;
   localparam int C_W   = 64;
   localparam int TAG_W = 8;
   localparam int CNT_W = 16;
   localparam logic [OP_W-1:0] Q = OP_W'(8380417);

   typedef enum logic [1:0] {EMPTY, S1_ONLY, S2_ONLY, FULL} pipe_state_e;

   function automatic pipe_state_e pipe_state(input logic s1_valid, input logic s2_valid);
      return pipe_state_e'({s2_valid, s1_valid});
   endfunction
endpackage

// File: rtl/barret_feeder_pipe_stage.sv
// barret_feeder_pipe_stage: one elastic valid/ready register slice for a W-bit payload
module barret_feeder_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   assign in_ready = !out_valid | out_ready;

   // Load when the slot is free or draining; payload only changes on a real transfer
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
endmodule

// File: rtl/barret_feeder.sv
// barret_feeder: two-stage elastic operand register -> multiplier -> product register ahead of the Barrett reducer
module barret_feeder
   import barret_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [C_W-1:0]   C,
   output logic [TAG_W-1:0] out_tag,
   output logic             range_err,
   output logic [CNT_W-1:0] issued_cnt,
   output logic             busy
);
   logic             s1_valid;
   logic             s2_ready;
   logic [OP_W-1:0]  s1_a;
   logic [OP_W-1:0]  s1_b;
   logic [TAG_W-1:0] s1_tag;
   logic [C_W-1:0]   prod;

   barret_feeder_pipe_stage #(.W(2*OP_W+TAG_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_a, in_b, in_tag}),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  ({s1_a, s1_b, s1_tag})
   );

   assign prod = C_W'(s1_a) * C_W'(s1_b);

   barret_feeder_pipe_stage #(.W(C_W+TAG_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   ({prod, s1_tag}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({C, out_tag})
   );

   assign busy = s1_valid | out_valid;

   // Sticky flag for any accepted operand outside [0, Q); the pair still flows through
   always_ff @(posedge clk or posedge rst)
      if (rst) range_err <= 1'b0;
      else if (in_valid && in_ready && (in_a >= Q || in_b >= Q)) range_err <= 1'b1;

   // Count handoffs to the reducer, wrapping naturally at the counter width
   always_ff @(posedge clk or posedge rst)
      if (rst) issued_cnt <= '0;
      else if (out_valid && out_ready) issued_cnt <= issued_cnt + CNT_W'(1);
endmodule

// File: tb/tb_barret_feeder.sv
// tb_barret_feeder: randomized and directed checks of barret_feeder against a queue-based reference model
module tb_barret_feeder;
   localparam logic [31:0] QM = 32'd8380417;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] C;
   logic [7:0]  out_tag;
   logic        range_err;
   logic [15:0] issued_cnt;
   logic        busy;

   typedef struct {
      logic [63:0] c;
      logic [7:0]  t;
      int          e;
   } item_t;

   item_t       q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] exp_cnt = '0;
   logic        exp_err = 1'b0;
   logic        acc;

   barret_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .C          (C),
      .out_tag    (out_tag),
      .range_err  (range_err),
      .issued_cnt (issued_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model is a FIFO of accepted pairs stamped with their acceptance cycle
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t, input logic o);
      logic ev;
      item_t it;
      in_valid = v; in_a = a; in_b = b; in_tag = t; out_ready = o;
      #1;
      ev = 1'b0;
      if (q.size() > 0) ev = (cyc >= q[0].e + 2);
      checks++;
      if (out_valid !== ev) begin errors++; $display("FAIL out_valid cyc=%0d got %b exp %b", cyc, out_valid, ev); end
      checks++;
      if (in_ready !== (q.size() < 2 || o)) begin errors++; $display("FAIL in_ready cyc=%0d got %b exp %b", cyc, in_ready, (q.size() < 2 || o)); end
      checks++;
      if (busy !== (q.size() > 0)) begin errors++; $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, q.size() > 0); end
      if (out_valid && q.size() > 0) begin
         checks++;
         if (C !== q[0].c || out_tag !== q[0].t) begin
            errors++; $display("FAIL product cyc=%0d got C=%0d tag=%h exp C=%0d tag=%h", cyc, C, out_tag, q[0].c, q[0].t);
         end
         if (o) begin void'(q.pop_front()); exp_cnt++; end
      end
      acc = v && in_ready;
      if (acc) begin
         it.c = {32'd0, a} * {32'd0, b}; it.t = t; it.e = cyc;
         q.push_back(it);
         if (a >= QM || b >= QM) exp_err = 1'b1;
      end
      @(posedge clk);
      cyc++;
      #1;
      checks++;
      if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL issued_cnt cyc=%0d got %0d exp %0d", cyc, issued_cnt, exp_cnt); end
      checks++;
      if (range_err !== exp_err) begin errors++; $display("FAIL range_err cyc=%0d got %b exp %b", cyc, range_err, exp_err); end
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      q.delete(); exp_cnt = '0; exp_err = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || issued_cnt !== 16'd0 || C !== 64'd0 || out_tag !== 8'd0 || range_err !== 1'b0) begin
         errors++; $display("FAIL reset_values got ov=%b busy=%b cnt=%0d C=%0d tag=%h err=%b exp all zero", out_valid, busy, issued_cnt, C, out_tag, range_err);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_single();
      int n = 0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (out_valid) begin
            n++;
            checks++;
            if (C !== 64'd15 || out_tag !== 8'h11) begin errors++; $display("FAIL single_C got %0d/%h exp 15/11", C, out_tag); end
         end
         cycle(k == 0, 32'd3, 32'd5, 8'h11, 1'b1);
      end
      checks++;
      if (n != 1) begin errors++; $display("FAIL single_pulse got %0d cycles exp 1", n); end
      checks++;
      if (issued_cnt !== 16'd1 || range_err !== 1'b0) begin errors++; $display("FAIL single_cnt got cnt=%0d err=%b exp 1/0", issued_cnt, range_err); end
   endtask

   task automatic test_max();
      logic [63:0] got = '0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (out_valid) got = C;
         cycle(k == 0, QM - 1, QM - 1, 8'h5a, 1'b1);
      end
      checks++;
      if (got !== 64'd70231372333056 || range_err !== 1'b0) begin errors++; $display("FAIL max_product got %0d err=%b exp 70231372333056/0", got, range_err); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int first = -1;
      int last = -1;
      do_reset();
      for (int k = 0; k < 15; k++) begin
         if (out_valid) begin
            n++;
            if (first < 0) first = k;
            last = k;
            checks++;
            if (C !== 64'((k - 2) * (k - 1))) begin errors++; $display("FAIL b2b_C k=%0d got %0d exp %0d", k, C, (k - 2) * (k - 1)); end
         end
         cycle(k < 10, 32'(k), 32'(k + 1), 8'(k), 1'b1);
      end
      checks++;
      if (n != 10 || last - first != 9) begin errors++; $display("FAIL b2b_run got n=%0d span=%0d exp 10/9", n, last - first); end
      checks++;
      if (issued_cnt !== 16'd10) begin errors++; $display("FAIL b2b_cnt got %0d exp 10", issued_cnt); end
   endtask

   task automatic test_stall();
      int i = 0;
      logic [63:0] held = '0;
      do_reset();
      for (int k = 0; k < 40 && (i < 10 || busy); k++) begin
         if (k == 3) held = C;
         if (k >= 4 && k <= 7) begin
            checks++;
            if (C !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
               errors++; $display("FAIL stall_hold k=%0d got C=%0d ov=%b rdy=%b exp C=%0d ov=1 rdy=0", k, C, out_valid, in_ready, held);
            end
         end
         cycle(i < 10, 32'(i), 32'(i + 1), 8'($urandom), !(k >= 3 && k <= 7));
         if (acc) i++;
      end
      checks++;
      if (issued_cnt !== 16'd10 || q.size() != 0) begin errors++; $display("FAIL stall_cnt got %0d left=%0d exp 10/0", issued_cnt, q.size()); end
   endtask

   task automatic test_range();
      logic [63:0] got = '0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (out_valid && k == 2) got = C;
         cycle(k < 4, k == 0 ? QM : $urandom_range(0, QM - 1), k == 0 ? 32'd1 : $urandom_range(0, QM - 1), 8'(k), 1'b1);
         checks++;
         if (range_err !== 1'b1) begin errors++; $display("FAIL range_sticky k=%0d got %b exp 1", k, range_err); end
      end
      checks++;
      if (got !== 64'd8380417) begin errors++; $display("FAIL range_C got %0d exp 8380417", got); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] got = '0;
      do_reset();
      cycle(1'b1, 32'd9, 32'd9, 8'h01, 1'b1);
      drain(2);
      cycle(1'b1, 32'd4, 32'd4, 8'h02, 1'b0);
      cycle(1'b1, 32'd6, 32'd6, 8'h03, 1'b0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || issued_cnt !== 16'd1) begin errors++; $display("FAIL mid_full got busy=%b rdy=%b cnt=%0d exp 1/0/1", busy, in_ready, issued_cnt); end
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (out_valid) got = C;
         cycle(k == 0, 32'd2, 32'd7, 8'h04, 1'b1);
      end
      checks++;
      if (got !== 64'd14 || issued_cnt !== 16'd1) begin errors++; $display("FAIL mid_after got C=%0d cnt=%0d exp 14/1", got, issued_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++)
         cycle($urandom_range(0, 3) != 0,
               ($urandom_range(0, 31) == 0) ? $urandom : $urandom_range(0, QM - 1),
               ($urandom_range(0, 31) == 0) ? $urandom : $urandom_range(0, QM - 1),
               8'($urandom), $urandom_range(0, 2) != 0);
      drain(4);
      checks++;
      if (q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL random_drain got left=%0d busy=%b exp 0/0", q.size(), busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_max();
      test_back_to_back();
      test_stall();
      test_range();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
